// File: rtl/decode_pkg.sv
// Shared types and field widths for the fetch-to-execute instruction path.
// Optional build macro STALL_CNT_EN (used by instr_decode_reg) adds a stall counter.
package decode_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int IMM_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef logic [INSTR_W-1:0] instr_t;

  // Opcode encoding shared with the execute stage.
  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_JMP  = 4'hD,
    OP_CALL = 4'hE,
    OP_RET  = 4'hF
  } opcode_t;

endpackage

// File: rtl/instr_decode_reg_if.sv
// Fetch-side and execute-side handshake bundle of the decode pipeline register.
// master = upstream/downstream environment view, slave = decode register view.
interface instr_decode_reg_if;
  import decode_pkg::*;

  logic             in_valid;
  logic             in_ready;
  instr_t           in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [OPC_W-1:0] out_opcode;
  logic [IMM_W-1:0] out_imm;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_imm
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_imm
  );

endinterface

// File: rtl/instr_skid_buf.sv
// Generic two-entry valid/ready skid buffer: main register drives the output,
// skid register catches the beat accepted while the head is stalled.
//   state | meaning
//   EMPTY | nothing held, out_valid low
//   MAIN  | head entry in main, skid free
//   FULL  | main and skid both hold data, in_ready low
module instr_skid_buf
  import decode_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_MAIN  = MAIN;
  localparam logic [1:0] ST_FULL  = FULL;

  logic [1:0]   state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;

  // Ready and valid depend only on registered state, never on the opposite handshake.
  assign in_ready  = (state != ST_FULL) && !rst;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= ST_FULL;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ST_MAIN;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/instr_decode_reg.sv
// Decode pipeline register: buffers fetched instructions and splits them into
// opcode/immediate fields. Define STALL_CNT_EN to add the saturating stall_cnt output.
module instr_decode_reg
  import decode_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  instr_decode_reg_if.slave bus
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  generate
    if (OPC_W + IMM_W != INSTR_W) begin : g_width_check
      $error("opcode and immediate fields must exactly cover the instruction");
    end
  endgenerate

  instr_t head;

  instr_skid_buf #(.W(INSTR_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (bus.in_instr),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
  );

  assign bus.out_opcode = head[INSTR_W-1 -: OPC_W];
  assign bus.out_imm    = head[IMM_W-1:0];

`ifdef STALL_CNT_EN
  // Only reset clears the counter; a flush keeps the stall history.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_reg.sv
// Directed and scoreboard-checked bench for the instr_decode_reg pipeline register.
// Stall counter checks are included when STALL_CNT_EN is defined.
module tb_instr_decode_reg;
  import decode_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;

  instr_decode_reg_if bus();

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  instr_decode_reg dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] opc,
                           input logic [3:0] imm);
    check({tag, "_valid"}, 16'(bus.out_valid), 16'(v));
    if (v) begin
      check({tag, "_opcode"}, 16'(bus.out_opcode), 16'(opc));
      check({tag, "_imm"}, 16'(bus.out_imm), 16'(imm));
    end
  endtask

  task automatic offer(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_instr = d;
  endtask

  initial begin
    instr_t q[$];
    instr_t exp_word;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    check("rst_valid", 16'(bus.out_valid), 16'd0);
    check("rst_opcode", 16'(bus.out_opcode), 16'd0);
    check("rst_imm", 16'(bus.out_imm), 16'd0);
    check("rst_in_ready", 16'(bus.in_ready), 16'd0);
`ifdef STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 16'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

    // Streaming at full rate
    bus.out_ready = 1'b1;
    offer(1'b1, 8'hA3); tick();
    check_out("stream_a3", 1'b1, 4'hA, 4'h3);
    check("stream_rdy0", 16'(bus.in_ready), 16'd1);
    offer(1'b1, 8'h5C); tick();
    check_out("stream_5c", 1'b1, 4'h5, 4'hC);
    check("stream_rdy1", 16'(bus.in_ready), 16'd1);
    offer(1'b1, 8'hF0); tick();
    check_out("stream_f0", 1'b1, 4'hF, 4'h0);
    check("stream_rdy2", 16'(bus.in_ready), 16'd1);
    offer(1'b0, 8'h00); tick();
    check_out("stream_drain", 1'b0, 4'h0, 4'h0);

    // Backpressure into FULL, then release
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h12); tick();
    check_out("bp_main", 1'b1, 4'h1, 4'h2);
    offer(1'b1, 8'h34); tick();
    check_out("bp_full", 1'b1, 4'h1, 4'h2);
    check("bp_full_rdy", 16'(bus.in_ready), 16'd0);
    offer(1'b1, 8'h56); tick();
    check_out("bp_hold", 1'b1, 4'h1, 4'h2);
    check("bp_hold_rdy", 16'(bus.in_ready), 16'd0);
    offer(1'b0, 8'h00);
    bus.out_ready = 1'b1;
    #1;
    check_out("bp_deliver0", 1'b1, 4'h1, 4'h2);
    tick();
    check_out("bp_deliver1", 1'b1, 4'h3, 4'h4);
    check("bp_deliver1_rdy", 16'(bus.in_ready), 16'd1);
    tick();
    check_out("bp_empty", 1'b0, 4'h0, 4'h0);

    // Flush from FULL; beats offered during flush are lost
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h12); tick();
    offer(1'b1, 8'h34); tick();
    check("fl_full_rdy", 16'(bus.in_ready), 16'd0);
    flush = 1'b1;
    offer(1'b1, 8'h77); tick();
    flush = 1'b0;
    check_out("fl_empty", 1'b0, 4'h0, 4'h0);
    check("fl_rdy", 16'(bus.in_ready), 16'd1);
    // Flush while a beat is actually accepted (state MAIN, in_ready=1)
    offer(1'b1, 8'h21); tick();
    flush = 1'b1;
    offer(1'b1, 8'h77); tick();
    flush = 1'b0;
    check_out("fl_accept_drop", 1'b0, 4'h0, 4'h0);
    bus.out_ready = 1'b1;
    offer(1'b1, 8'h99); tick();
    check_out("fl_after", 1'b1, 4'h9, 4'h9);
    offer(1'b0, 8'h00); tick();
    check_out("fl_after_drain", 1'b0, 4'h0, 4'h0);

    // Reset while FULL
    bus.out_ready = 1'b0;
    offer(1'b1, 8'hBE); tick();
    offer(1'b1, 8'hEF); tick();
    check("rf_full_rdy", 16'(bus.in_ready), 16'd0);
    offer(1'b0, 8'h00);
    rst = 1'b1;
    tick();
    check("rf_valid", 16'(bus.out_valid), 16'd0);
    check("rf_opcode", 16'(bus.out_opcode), 16'd0);
    check("rf_imm", 16'(bus.out_imm), 16'd0);
    check("rf_rdy", 16'(bus.in_ready), 16'd0);
    rst = 1'b0;
    #1;
    check("rf_rdy_after", 16'(bus.in_ready), 16'd1);
    tick();
    check("rf_still_empty", 16'(bus.out_valid), 16'd0);

    // Random handshakes against a FIFO scoreboard
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_instr  = 8'($urandom_range(0, 255));
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      check("rnd_in_ready", 16'(bus.in_ready), 16'(q.size() != 2));
      check("rnd_out_valid", 16'(bus.out_valid), 16'(q.size() != 0));
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        exp_word = q.pop_front();
        check("rnd_data", 16'({bus.out_opcode, bus.out_imm}), 16'(exp_word));
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_instr);
      tick();
    end
    offer(1'b0, 8'h00);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4 && q.size() != 0; i++) begin
      #1;
      if (bus.out_valid) begin
        exp_word = q.pop_front();
        check("drain_data", 16'({bus.out_opcode, bus.out_imm}), 16'(exp_word));
      end
      tick();
    end
    check("drain_left", 16'(q.size()), 16'd0);
    check("drain_valid", 16'(bus.out_valid), 16'd0);

`ifdef STALL_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sc_rst", stall_cnt, 16'd0);
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h42); tick();
    offer(1'b0, 8'h00);
    check("sc_start", stall_cnt, 16'd0);
    repeat (3) tick();
    check("sc_three", stall_cnt, 16'd3);
    repeat (70000) tick();
    check("sc_sat", stall_cnt, 16'hFFFF);
    tick();
    check("sc_sat_hold", stall_cnt, 16'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sc_flush", stall_cnt, 16'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sc_rst_clear", stall_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
